// File: rtl/mod6_pkg.sv
// rtl/mod6_pkg.sv - shared constants for the mod-6 counter tile
// Holds default modulus/width, seven-segment patterns (gfedcba, active-high)
// and the fixed uio output-enable value.
package mod6_pkg;

    localparam int DEFAULT_MODULUS = 6;
    localparam int DEFAULT_CW      = 3;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [7:0] UIO_OE_VALUE = 8'h0F;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational count to seven-segment decoder
// Ports:
//   count : CW-bit binary count (0..5 meaningful)
//   seg   : 7-bit gfedcba pattern, active-high; blank for codes >= 6
module seg7_decoder
    import mod6_pkg::*;
#(
    parameter int CW = DEFAULT_CW
) (
    input  logic [CW-1:0] count,
    output logic [6:0]    seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (count)
            CW'(0): seg = SEG_0;
            CW'(1): seg = SEG_1;
            CW'(2): seg = SEG_2;
            CW'(3): seg = SEG_3;
            CW'(4): seg = SEG_4;
            CW'(5): seg = SEG_5;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/mod6_counter.sv
// rtl/mod6_counter.sv - modulo-6 up/down counter tile with seven-segment output
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous reset, active HIGH (despite the name)
//   ena     : tile enable; 0 freezes all state
//   ui_in   : [0] cnt_en, [1] dir (1=up), [2] clr, [3] load, [6:4] load value
//   uo_out  : [6:0] segments gfedcba, [7] terminal count (combinational)
//   uio_in  : ignored
//   uio_out : [2:0] count, [3] registered wrap pulse, [7:4] zero
//   uio_oe  : constant 8'h0F
module mod6_counter
    import mod6_pkg::*;
#(
    parameter int MODULUS = DEFAULT_MODULUS,
    parameter int CW      = DEFAULT_CW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [CW-1:0] MAX_COUNT = CW'(MODULUS - 1);

    logic          cnt_en;
    logic          dir;
    logic          clr;
    logic          load;
    logic [2:0]    load_val;
    logic [CW-1:0] count;
    logic          wrap;
    logic          tc;
    logic [6:0]    seg;
    logic          unused_ok;

    assign cnt_en   = ui_in[0];
    assign dir      = ui_in[1];
    assign clr      = ui_in[2];
    assign load     = ui_in[3];
    assign load_val = ui_in[6:4];

    assign unused_ok = &{1'b0, uio_in, ui_in[7]};

    // tc is exactly "this enabled edge will wrap", so the wrap register
    // simply captures it; clear and load suppress tc and hence never set wrap.
    assign tc = ena & cnt_en & ~clr & ~load &
                ((dir & (count == MAX_COUNT)) | (~dir & (count == '0)));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (ena) begin
            wrap <= tc;
            if (clr) begin
                count <= '0;
            end else if (load) begin
                if (32'(load_val) >= MODULUS) begin
                    count <= MAX_COUNT;
                end else begin
                    count <= CW'(load_val);
                end
            end else if (cnt_en) begin
                if (dir) begin
                    count <= (count == MAX_COUNT) ? '0 : count + CW'(1);
                end else begin
                    count <= (count == '0) ? MAX_COUNT : count - CW'(1);
                end
            end
        end
    end

    seg7_decoder #(
        .CW (CW)
    ) u_seg7 (
        .count (count),
        .seg   (seg)
    );

    assign uo_out  = {tc, seg};
    assign uio_out = {4'b0000, wrap, count};
    assign uio_oe  = UIO_OE_VALUE;

endmodule

// File: tb/tb_mod6_counter.sv
// tb/tb_mod6_counter.sv - self-checking bench for mod6_counter
module tb_mod6_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cnt  = 0;
    bit m_wrap = 1'b0;

    logic [6:0] seg_tab [6] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D};

    always #5 clk = ~clk;

    mod6_counter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Reference: count is an integer in 0..5, stepping with modular arithmetic.
    function automatic void model_next(input int cnt, input bit wr, input bit en,
                                       input logic [7:0] ui,
                                       output int ncnt, output bit nwrap);
        int v;
        ncnt  = cnt;
        nwrap = 1'b0;
        if (!en) begin
            nwrap = wr;
        end else if (ui[2]) begin
            ncnt = 0;
        end else if (ui[3]) begin
            v    = int'(ui[6:4]);
            ncnt = (v > 5) ? 5 : v;
        end else if (ui[0]) begin
            if (ui[1]) begin
                nwrap = (cnt + 1) >= 6;
                ncnt  = (cnt + 1) % 6;
            end else begin
                nwrap = (cnt - 1) < 0;
                ncnt  = (cnt + 5) % 6;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int  nc;
        bit  nw;
        bit  tc_exp;
        model_next(m_cnt, 1'b0, 1'b1, ui_in, nc, nw);
        tc_exp = ena && nw;
        check("uo_out",  uo_out,  {tc_exp, seg_tab[m_cnt]});
        check("uio_out", uio_out, {4'b0000, m_wrap, 3'(m_cnt)});
        check("uio_oe",  uio_oe,  8'h0F);
    endtask

    // Drive after a falling edge, check the pre-edge view, then advance one edge.
    task automatic cycle(input logic [7:0] ui, input logic en);
        int nc;
        bit nw;
        ui_in = ui;
        ena   = en;
        #1;
        check_state();
        @(posedge clk);
        model_next(m_cnt, m_wrap, en, ui, nc, nw);
        m_cnt  = nc;
        m_wrap = nw;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] r;
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        check_state();
        rst_n = 1'b0;
        @(negedge clk);

        // Up count through a wrap
        repeat (7) cycle(8'h03, 1'b1);

        // Down count from 0 through a wrap
        cycle(8'h04, 1'b1);
        repeat (7) cycle(8'h01, 1'b1);

        // Load and clamp, clear beats load
        cycle(8'h38, 1'b1);
        cycle(8'h78, 1'b1);
        cycle(8'h3C, 1'b1);
        cycle(8'h00, 1'b1);

        // Enable gating, then load beats count at the terminal value
        cycle(8'h48, 1'b1);
        repeat (5) cycle(8'h03, 1'b0);
        cycle(8'h03, 1'b1);
        cycle(8'h0B, 1'b1);
        cycle(8'h00, 1'b1);

        // Wrap pulse must hold while disabled
        cycle(8'h58, 1'b1);
        cycle(8'h03, 1'b1);
        repeat (2) cycle(8'h03, 1'b0);
        cycle(8'h00, 1'b1);

        // Asynchronous reset mid-count
        repeat (2) cycle(8'h03, 1'b1);
        #2;
        rst_n = 1'b1;
        #1;
        m_cnt  = 0;
        m_wrap = 1'b0;
        check_state();
        @(negedge clk);
        rst_n = 1'b0;
        cycle(8'h03, 1'b1);

        // Randomized traffic, clear/load kept rare so counting dominates
        repeat (400) begin
            r = 8'($urandom);
            if ($urandom_range(0, 4) != 0) r[2] = 1'b0;
            if ($urandom_range(0, 3) != 0) r[3] = 1'b0;
            cycle(r, $urandom_range(0, 7) != 0);
        end

        #1;
        check_state();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod6_counter.md
Name: mod6_counter

Overview:
- Tiny-Tapeout-style user block: a modulo-6 up/down counter with synchronous clear, parallel load, and a seven-segment display of the current count.
- Sits directly behind the standard tile pin interface: ui_in for controls, uo_out for the display, uio for binary status.
- All state is in a single clock domain.

Parameters:
- MODULUS, 6, counting modulus; the count range is 0..MODULUS-1.
- CW, 3, count width in bits; must satisfy 2^CW >= MODULUS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-high reset. When rst_n=1, state clears immediately, independent of clk.
- ena  in  1  tile enable. When 0, all state holds (reset still acts).
- ui_in  in  8  controls:
  - [0] cnt_en
  - [1] dir (1=up, 0=down)
  - [2] clr
  - [3] load
  - [6:4] load value
  - [7] unused
- uo_out  out  8  [6:0] seven-segment pattern (gfedcba, active-high); [7] terminal-count (tc).
- uio_in  in  8  unused, ignored.
- uio_out  out  8  [2:0] binary count; [3] wrap pulse; [7:4] = 0.
- uio_oe  out  8  constant 8'h0F.

Behaviour:
- Reset (rst_n=1, asynchronous):
  - count=0, wrap=0.
  - Consequently uo_out=8'h3F and uio_out=8'h00.
  - uio_oe stays 8'h0F at all times.
- Rising-edge update priority, evaluated only when ena=1: clr > load > cnt_en > hold.
  - clr=1: count<=0.
  - load=1: count <= ui_in[6:4], clamped to MODULUS-1 when ui_in[6:4] >= MODULUS (6 or 7 loads 5).
  - cnt_en=1, dir=1: count<=count+1; 5 wraps to 0.
  - cnt_en=1, dir=0: count<=count-1; 0 wraps to 5.
  - Otherwise hold.
- ena=0: count and wrap hold their values; all ui_in controls are ignored.
- Count never leaves 0..5 under any input sequence.
- tc (combinational) = ena & cnt_en & ~clr & ~load & ((dir & count==5) | (~dir & count==0)).
  - tc is high exactly in the cycle before a wrap edge.
- wrap (registered): set to 1 on the edge where a wrap occurs (5→0 up, 0→5 down); otherwise cleared on every enabled edge.
  - Produces a one-cycle pulse that lags tc by one cycle.
  - Clear and load never set wrap.
- Seven-segment encoding (combinational from count):
  - 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D.
  - Unreachable codes 6/7 → 7'h00.
- Latency: outputs reflect a new count in the same cycle it is registered; no pipeline.
- Reset mid-count: count returns to 0 at once. On the first edge after release, normal priority applies.
- Direction change takes effect on the next enabled edge; no extra state.

Decomposition:
- Shared package mod6_pkg holds:
  - MODULUS and CW defaults
  - the six segment constants SEG_0..SEG_5 and SEG_BLANK
  - the uio_oe constant 8'h0F
- Sub-module seg7_decoder: CW-bit count in, 7-bit gfedcba pattern out; purely combinational.
- Counter, tc and wrap logic live in the top block.

Test Plan:
- Reset: assert rst_n=1 mid-cycle → uo_out=8'h3F and uio_out=8'h00 immediately (before the next edge); uio_oe=8'h0F.
- Up count: ena=1, ui_in=8'h03, 7 edges →
  - uio_out[2:0] sequence 1,2,3,4,5,0,1
  - tc=1 only while count=5
  - uio_out[3]=1 only in the cycle after 5→0
- Down count: ui_in=8'h01 starting from 0 → count sequence 5,4,3,2,1,0,5; tc high at count=0; wrap pulse after 0→5.
- Load/clamp:
  - ui_in = load=1, value 3 (8'h38) → count=3, uo_out[6:0]=7'h4F
  - value 7 (8'h78) → count=5, segments 7'h6D
  - clr and load together (8'h3C) → count=0
- Enable gating: count=4, ena=0 with ui_in=8'h03 for 5 edges → count stays 4, wrap stays 0. Restore ena=1 → next edge gives 5.
- Priority: count=5, ui_in=8'h0B (load value 0 with counting up) → count=0 via load, tc=0 that cycle, no wrap pulse.
